fir_conv5x5: RTL and testbench
==============================

# fir_conv5x5

Arithmetic stage directly downstream of the 5×5 window generator. It takes the 25-pixel luma window, the window position and the video sync signals, and computes a signed 5×5 convolution. The result is rounded, scaled and saturated to 8 bits, then driven as grey RGB. Sync signals are delayed to match the fixed pipeline latency. Coefficients are runtime-loadable and double-buffered, so a kernel change takes effect only at a frame boundary.

## Interface
Parameters:
- SHIFT, 4, right-shift applied to the accumulator (1..8)
- BORDER, 4, minimum x_index/y_index for a fully populated window

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- pixel_00 … pixel_44  in  8 each  window pixels; first digit is the row (0 = newest row), second digit is the column (0 = newest column)
- x_index  in  11  column index of the current window
- y_index  in  10  row index of the current window
- dv_i, hs_i, vs_i  in  1 each  sync signals aligned with the window
- coef_we  in  1  coefficient write strobe
- coef_addr  in  5  coefficient index, computed as row*5 + col (0..24)
- coef_data  in  8  signed two's-complement coefficient
- r_o, g_o, b_o  out  8 each  filtered luma, replicated on all three channels
- dv_o, hs_o, vs_o  out  1 each  sync signals delayed by 4 cycles

## Operation
- Coefficient banks:
  - There is a shadow bank and an active bank, each holding 25 × 8-bit signed entries.
  - A write with coef_we=1 and coef_addr<25 updates the shadow entry. A write with coef_addr≥25 is ignored.
  - On a rising edge of vs_i (vs_i=1 and the previous vs_i=0), the active bank is loaded from the shadow bank.
  - If a write and a commit occur in the same cycle, the commit copies the pre-write shadow contents. The new write becomes active at the next commit.
- Reset state: both banks hold the identity kernel, which is entry 12 = 2^SHIFT and all other entries 0. With SHIFT=8, entry 12 saturates to 127.
- Products: each pixel is zero-extended to 9 bits signed and multiplied by its coefficient, giving a 17-bit signed product.
- Accumulation:
  - Each of the five row sums is 20-bit signed.
  - The total sum is 22-bit signed and cannot overflow.
- Rounding: add 2^(SHIFT-1) to the total, then shift right arithmetically by SHIFT.
- Saturation: results below 0 give 0; results above 255 give 255.
- Border handling:
  - window_ok = (x_index ≥ BORDER) && (y_index ≥ BORDER), sampled together with the pixels.
  - When window_ok=0, the output is pixel_22 (the centre pixel) delayed through the pipeline, instead of the filter result.
- The pipeline advances every cycle and never stalls. Pixels are processed regardless of dv_i, and dv_i only travels with the data.

## Timing
Pipeline stages:
- S1 registers the 25 products, pixel_22, window_ok and the syncs.
- S2 registers the five row sums.
- S3 registers the total sum plus the rounding constant.
- S4 registers the shifted, saturated and border-selected result onto the outputs.

Latency and alignment:
- Latency is exactly 4 cycles from the inputs being sampled to r/g/b_o. dv_o, hs_o and vs_o are aligned with the data.
- A commit takes effect on the pixels sampled in the cycle after the vs_i rising edge.

Reset:
- With rst=0, all outputs and pipeline registers are cleared to 0 immediately and asynchronously. Both banks return to identity.
- If reset is asserted mid-frame, data in flight is discarded. The outputs then stay 0 for 4 cycles after rst is released, while the pipeline refills.

## Structure
- Package fir_pkg contains:
  - constants KW=5, PIX_W=8, COEF_W=8, PROD_W=17, ROW_W=20, ACC_W=22
  - a coef_t typedef for an 8-bit signed coefficient
  - the function identity_coef(idx, shift)
  - the sync bundle struct {dv, hs, vs}
- Sub-module fir_row_mac5:
  - inputs: 5 pixels and 5 coefficients
  - behaviour: registered products, then a registered 20-bit row sum
  - latency: 2 cycles
  - instantiated five times.

## Test plan
- Identity after reset: drive pixel_22=100, other pixels=7, window_ok=1, with dv_i pulsed → r/g/b_o=100 exactly 4 cycles later, with dv_o aligned.
- Box kernel: write all 25 coefficients = 1, pulse vs_i, then drive all pixels = 16 → (400+8)>>4 = 25. Drive all pixels = 200 → saturates to 255.
- Negative clamp: load centre = 0 and others = -1, commit, then drive all pixels = 50 → 0.
- Double buffering:
  - Write entry 12 = 32 mid-frame → output is unchanged (still identity).
  - After the vs_i rising edge, pixel_22=50 with others 0 → (1600+8)>>4 = 100.
  - Repeat the test with the write landing in the same cycle as the vs_i rising edge → the new value appears only after the next vs_i rising edge.
- Border: drive x_index=2, y_index=10 with the box kernel loaded and pixel_22=77 → 77. Drive x_index=4 → filtered value.
- Reset mid-stream: stream a ramp of pixels and assert rst for 1 cycle → outputs go to 0 immediately and the kernel returns to identity. The first valid output appears 4 cycles after release.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, types and helpers for the 5x5 convolution stage.
package fir_pkg;

   localparam int KW     = 5;
   localparam int NCOEF  = KW * KW;
   localparam int PIX_W  = 8;
   localparam int COEF_W = 8;
   localparam int PROD_W = 17;
   localparam int ROW_W  = 20;
   localparam int ACC_W  = 22;

   typedef logic signed [COEF_W-1:0] coef_t;

   typedef struct packed {
      logic dv;
      logic hs;
      logic vs;
   } sync_t;

   // Identity kernel entry: centre tap is 2^shift, clipped to the largest positive coefficient.
   function automatic coef_t identity_coef(input int unsigned idx, input int unsigned shift);
      if (idx != 12) return '0;
      if (shift >= 7) return coef_t'(127);
      return coef_t'(1 << shift);
   endfunction

endpackage

// File: rtl/fir_conv5x5_if.sv
// Window/sync/coefficient inputs and grey-RGB/sync outputs of the convolution stage.
interface fir_conv5x5_if;
   import fir_pkg::*;

   logic [PIX_W-1:0] pixel_00, pixel_01, pixel_02, pixel_03, pixel_04;
   logic [PIX_W-1:0] pixel_10, pixel_11, pixel_12, pixel_13, pixel_14;
   logic [PIX_W-1:0] pixel_20, pixel_21, pixel_22, pixel_23, pixel_24;
   logic [PIX_W-1:0] pixel_30, pixel_31, pixel_32, pixel_33, pixel_34;
   logic [PIX_W-1:0] pixel_40, pixel_41, pixel_42, pixel_43, pixel_44;
   logic [10:0]       x_index;
   logic [9:0]        y_index;
   logic              dv_i, hs_i, vs_i;
   logic              coef_we;
   logic [4:0]        coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic [PIX_W-1:0]  r_o, g_o, b_o;
   logic              dv_o, hs_o, vs_o;

   modport master (
      output pixel_00, pixel_01, pixel_02, pixel_03, pixel_04,
             pixel_10, pixel_11, pixel_12, pixel_13, pixel_14,
             pixel_20, pixel_21, pixel_22, pixel_23, pixel_24,
             pixel_30, pixel_31, pixel_32, pixel_33, pixel_34,
             pixel_40, pixel_41, pixel_42, pixel_43, pixel_44,
             x_index, y_index, dv_i, hs_i, vs_i, coef_we, coef_addr, coef_data,
      input  r_o, g_o, b_o, dv_o, hs_o, vs_o
   );

   modport slave (
      input  pixel_00, pixel_01, pixel_02, pixel_03, pixel_04,
             pixel_10, pixel_11, pixel_12, pixel_13, pixel_14,
             pixel_20, pixel_21, pixel_22, pixel_23, pixel_24,
             pixel_30, pixel_31, pixel_32, pixel_33, pixel_34,
             pixel_40, pixel_41, pixel_42, pixel_43, pixel_44,
             x_index, y_index, dv_i, hs_i, vs_i, coef_we, coef_addr, coef_data,
      output r_o, g_o, b_o, dv_o, hs_o, vs_o
   );

endinterface

// File: rtl/fir_row_mac5.sv
// One kernel row: registered pixel*coef products, then a registered 20-bit row sum.
module fir_row_mac5
   import fir_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [PIX_W-1:0]        i_pix  [KW],
   input  coef_t                   i_coef [KW],
   output logic signed [ROW_W-1:0] o_sum
);

   logic signed [PROD_W-1:0] w_prod [KW];
   logic signed [PROD_W-1:0] r_prod [KW];
   logic signed [ROW_W-1:0]  w_sum;
   logic signed [ROW_W-1:0]  r_sum;

   // Pixels are unsigned, so they are zero-extended before the signed multiply.
   for (genvar g = 0; g < KW; g++) begin : g_mul
      assign w_prod[g] = PROD_W'($signed({1'b0, i_pix[g]})) * PROD_W'(i_coef[g]);
   end

   // Sign-extend each product before adding so the row sum cannot wrap.
   always_comb begin
      w_sum = ROW_W'(r_prod[0]) + ROW_W'(r_prod[1]) + ROW_W'(r_prod[2])
            + ROW_W'(r_prod[3]) + ROW_W'(r_prod[4]);
   end

   // Two pipeline registers: products, then the row sum.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prod <= '{default: '0};
         r_sum  <= '0;
      end else begin
         r_prod <= w_prod;
         r_sum  <= w_sum;
      end
   end

   assign o_sum = r_sum;

endmodule

// File: rtl/fir_conv5x5.sv
// 5x5 signed convolution on a luma window with frame-synchronous double-buffered coefficients.
module fir_conv5x5
   import fir_pkg::*;
#(
   parameter int SHIFT  = 4,
   parameter int BORDER = 4
) (
   input  logic         clk,
   input  logic         rst,
   fir_conv5x5_if.slave bus
);

   localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(1 << (SHIFT - 1));

   logic [PIX_W-1:0]        w_pix  [KW][KW];
   coef_t                   w_coef [KW][KW];
   logic signed [ROW_W-1:0] w_row  [KW];
   logic                    r_vs_prev;
   logic                    w_commit;
   logic                    w_ok;
   sync_t                   w_sync;
   logic                    r_ok1, r_ok2, r_ok3;
   logic [PIX_W-1:0]        r_c22_1, r_c22_2, r_c22_3;
   sync_t                   r_sync1, r_sync2, r_sync3, r_sync_o;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] w_shift;
   logic [PIX_W-1:0]        w_sat;
   logic [PIX_W-1:0]        r_y;

   // Row 0 / column 0 hold the newest pixels.
   assign w_pix = '{
      '{bus.pixel_00, bus.pixel_01, bus.pixel_02, bus.pixel_03, bus.pixel_04},
      '{bus.pixel_10, bus.pixel_11, bus.pixel_12, bus.pixel_13, bus.pixel_14},
      '{bus.pixel_20, bus.pixel_21, bus.pixel_22, bus.pixel_23, bus.pixel_24},
      '{bus.pixel_30, bus.pixel_31, bus.pixel_32, bus.pixel_33, bus.pixel_34},
      '{bus.pixel_40, bus.pixel_41, bus.pixel_42, bus.pixel_43, bus.pixel_44}};

   assign w_commit = bus.vs_i & ~r_vs_prev;
   assign w_ok     = (bus.x_index >= 11'(BORDER)) && (bus.y_index >= 10'(BORDER));
   assign w_sync   = '{dv: bus.dv_i, hs: bus.hs_i, vs: bus.vs_i};

   // Remember the previous vs_i to detect the frame-start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_vs_prev <= 1'b0;
      else      r_vs_prev <= bus.vs_i;
   end

   // One shadow/active pair per tap; the address decode alone rejects addresses 25..31.
   // Nonblocking copy means a commit takes the pre-write shadow value.
   for (genvar g = 0; g < NCOEF; g++) begin : g_bank
      coef_t r_shd;
      coef_t r_act;

      // Shadow follows host writes; active reloads from shadow at frame start.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            r_shd <= identity_coef(g, SHIFT);
            r_act <= identity_coef(g, SHIFT);
         end else begin
            if (w_commit) r_act <= r_shd;
            if (bus.coef_we && (bus.coef_addr == 5'(g))) r_shd <= bus.coef_data;
         end
      end

      assign w_coef[g / KW][g % KW] = r_act;
   end

   for (genvar r = 0; r < KW; r++) begin : g_row
      fir_row_mac5 u_row (
         .clk    (clk),
         .rst    (rst),
         .i_pix  (w_pix[r]),
         .i_coef (w_coef[r]),
         .o_sum  (w_row[r])
      );
   end

   assign w_shift = r_acc >>> SHIFT;

   // Clamp the scaled sum into 0..255.
   always_comb begin
      w_sat = w_shift[PIX_W-1:0];
      if (w_shift[ACC_W-1])                 w_sat = '0;
      else if (|w_shift[ACC_W-2:PIX_W])     w_sat = '1;
   end

   // Side-band delay line, total+rounding stage and the output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ok1    <= 1'b0;
         r_ok2    <= 1'b0;
         r_ok3    <= 1'b0;
         r_c22_1  <= '0;
         r_c22_2  <= '0;
         r_c22_3  <= '0;
         r_sync1  <= '0;
         r_sync2  <= '0;
         r_sync3  <= '0;
         r_sync_o <= '0;
         r_acc    <= '0;
         r_y      <= '0;
      end else begin
         r_ok1    <= w_ok;
         r_ok2    <= r_ok1;
         r_ok3    <= r_ok2;
         r_c22_1  <= bus.pixel_22;
         r_c22_2  <= r_c22_1;
         r_c22_3  <= r_c22_2;
         r_sync1  <= w_sync;
         r_sync2  <= r_sync1;
         r_sync3  <= r_sync2;
         r_sync_o <= r_sync3;
         r_acc    <= ACC_W'(w_row[0]) + ACC_W'(w_row[1]) + ACC_W'(w_row[2])
                   + ACC_W'(w_row[3]) + ACC_W'(w_row[4]) + ROUND;
         r_y      <= r_ok3 ? w_sat : r_c22_3;
      end
   end

   assign bus.r_o  = r_y;
   assign bus.g_o  = r_y;
   assign bus.b_o  = r_y;
   assign bus.dv_o = r_sync_o.dv;
   assign bus.hs_o = r_sync_o.hs;
   assign bus.vs_o = r_sync_o.vs;

endmodule

// File: tb/tb_fir_conv5x5.sv
// Directed + randomized bench for fir_conv5x5 against an arithmetic reference model.
module tb_fir_conv5x5;
   import fir_pkg::*;

   localparam int SHIFT  = 4;
   localparam int BORDER = 4;
   localparam int LAT    = 3;   // post-edge checks before a sampled window appears on the outputs

   typedef struct {
      int y;
      bit dv;
      bit hs;
      bit vs;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fir_conv5x5_if bus();

   fir_conv5x5 #(.SHIFT(SHIFT), .BORDER(BORDER)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // stimulus variables
   int p [5][5];
   int xi, yi, addr, data;
   bit dv, hs, vs, we;
   // reference model state
   int m_shadow [25];
   int m_active [25];
   bit m_prev_vs;
   exp_t  q  [$];
   string tq [$];
   int n_cmp = 0;
   int n_bad = 0;

   function automatic int ident(int i);
      int v;
      v = (1 << SHIFT);
      if (v > 127) v = 127;
      return (i == 12) ? v : 0;
   endfunction

   function automatic int model_out();
      int acc;
      if (!(xi >= BORDER && yi >= BORDER)) return p[2][2];
      acc = 0;
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            acc += p[r][c] * m_active[r*5 + c];
      acc = (acc + (1 << (SHIFT - 1))) >>> SHIFT;
      if (acc < 0)   acc = 0;
      if (acc > 255) acc = 255;
      return acc;
   endfunction

   task automatic model_reset();
      exp_t z;
      z = '{y: 0, dv: 0, hs: 0, vs: 0};
      for (int i = 0; i < 25; i++) begin
         m_shadow[i] = ident(i);
         m_active[i] = ident(i);
      end
      m_prev_vs = 1'b0;
      q.delete();
      tq.delete();
      for (int i = 0; i < LAT; i++) begin
         q.push_back(z);
         tq.push_back("refill");
      end
   endtask

   task automatic drive();
      bus.pixel_00 = 8'(p[0][0]); bus.pixel_01 = 8'(p[0][1]); bus.pixel_02 = 8'(p[0][2]);
      bus.pixel_03 = 8'(p[0][3]); bus.pixel_04 = 8'(p[0][4]);
      bus.pixel_10 = 8'(p[1][0]); bus.pixel_11 = 8'(p[1][1]); bus.pixel_12 = 8'(p[1][2]);
      bus.pixel_13 = 8'(p[1][3]); bus.pixel_14 = 8'(p[1][4]);
      bus.pixel_20 = 8'(p[2][0]); bus.pixel_21 = 8'(p[2][1]); bus.pixel_22 = 8'(p[2][2]);
      bus.pixel_23 = 8'(p[2][3]); bus.pixel_24 = 8'(p[2][4]);
      bus.pixel_30 = 8'(p[3][0]); bus.pixel_31 = 8'(p[3][1]); bus.pixel_32 = 8'(p[3][2]);
      bus.pixel_33 = 8'(p[3][3]); bus.pixel_34 = 8'(p[3][4]);
      bus.pixel_40 = 8'(p[4][0]); bus.pixel_41 = 8'(p[4][1]); bus.pixel_42 = 8'(p[4][2]);
      bus.pixel_43 = 8'(p[4][3]); bus.pixel_44 = 8'(p[4][4]);
      bus.x_index   = 11'(xi);
      bus.y_index   = 10'(yi);
      bus.dv_i      = dv;
      bus.hs_i      = hs;
      bus.vs_i      = vs;
      bus.coef_we   = we;
      bus.coef_addr = 5'(addr);
      bus.coef_data = 8'(data);
   endtask

   task automatic set_all(input int v);
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            p[r][c] = v;
   endtask

   task automatic set_rand();
      for (int r = 0; r < 5; r++)
         for (int c = 0; c < 5; c++)
            p[r][c] = int'($urandom_range(0, 255));
   endtask

   // One clock: drive, predict, advance the model banks, then compare the oldest prediction.
   task automatic apply(input string tag);
      exp_t e;
      exp_t o;
      string t;
      drive();
      e.y  = model_out();
      e.dv = dv;
      e.hs = hs;
      e.vs = vs;
      q.push_back(e);
      tq.push_back(tag);
      if (vs && !m_prev_vs) m_active = m_shadow;
      if (we && addr < 25) m_shadow[addr] = data;
      m_prev_vs = vs;
      @(posedge clk);
      #1;
      o = q.pop_front();
      t = tq.pop_front();
      n_cmp++;
      assert (bus.r_o === 8'(o.y) && bus.g_o === 8'(o.y) && bus.b_o === 8'(o.y)) else begin
         n_bad++;
         $error("FAIL %s rgb: got %0d/%0d/%0d want %0d", t, bus.r_o, bus.g_o, bus.b_o, o.y);
      end
      n_cmp++;
      assert ({bus.dv_o, bus.hs_o, bus.vs_o} === {o.dv, o.hs, o.vs}) else begin
         n_bad++;
         $error("FAIL %s sync: got dv/hs/vs=%b%b%b want %b%b%b", t,
                bus.dv_o, bus.hs_o, bus.vs_o, o.dv, o.hs, o.vs);
      end
   endtask

   task automatic wr(input int a, input int d);
      we = 1'b1; addr = a; data = d; vs = 1'b0;
      set_rand();
      apply("coef_wr");
      we = 1'b0;
   endtask

   task automatic load_kernel(input int centre, input int other);
      for (int i = 0; i < 25; i++) wr(i, (i == 12) ? centre : other);
      vs = 1'b1; set_rand(); apply("commit");
      vs = 1'b0;
   endtask

   // Asynchronous reset between edges; outputs must clear without waiting for a clock.
   task automatic pulse_reset(input string tag);
      rst = 1'b0;
      #1;
      n_cmp++;
      assert ({bus.r_o, bus.g_o, bus.b_o, bus.dv_o, bus.hs_o, bus.vs_o} === 27'd0) else begin
         n_bad++;
         $error("FAIL %s: got rgb=%0d/%0d/%0d dv/hs/vs=%b%b%b want all 0", tag,
                bus.r_o, bus.g_o, bus.b_o, bus.dv_o, bus.hs_o, bus.vs_o);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      xi = 10; yi = 10; dv = 0; hs = 0; vs = 0; we = 0; addr = 0; data = 0;
      set_all(0);
      drive();
      #2;
      pulse_reset("reset_state");

      // identity kernel after reset
      set_all(7); p[2][2] = 100; dv = 1'b1;
      apply("ident_dv");
      dv = 1'b0;
      for (int k = 0; k < 6; k++) begin
         set_rand(); hs = k[0];
         apply("ident_rand");
      end
      hs = 1'b0;

      // box kernel with rounding and high clamp
      load_kernel(1, 1);
      set_all(16);  apply("box16");
      set_all(200); apply("box200");
      for (int k = 0; k < 4; k++) begin set_rand(); apply("box_rand"); end

      // negative clamp
      load_kernel(0, -1);
      set_all(50); apply("neg50");

      // double buffering: mid-frame write stays hidden until frame start
      load_kernel(16, 0);
      wr(12, 32);
      set_all(0); p[2][2] = 50;
      apply("db_old");
      vs = 1'b1; apply("db_commit_cycle");
      vs = 1'b0; apply("db_new");
      // write coinciding with the frame-start edge is deferred one frame
      we = 1'b1; addr = 12; data = 48; vs = 1'b1;
      apply("db_same_cycle");
      we = 1'b0; vs = 1'b0;
      apply("db_still_32");
      vs = 1'b1; apply("db_commit2");
      vs = 1'b0; apply("db_48");
      // out-of-range address must be ignored
      we = 1'b1; addr = 25; data = 99; apply("wr_addr25");
      addr = 31; apply("wr_addr31");
      we = 1'b0;
      vs = 1'b1; apply("commit3");
      vs = 1'b0; apply("after_ignored");

      // border selection
      load_kernel(1, 1);
      set_rand(); p[2][2] = 77;
      xi = 2;  yi = 10; apply("border_x2");
      xi = 3;  yi = 10; apply("border_x3");
      xi = 4;  yi = 10; apply("border_x4");
      xi = 10; yi = 3;  apply("border_y3");
      xi = 10; yi = 4;  apply("border_y4");

      // randomized traffic with live coefficient writes and frame starts
      for (int k = 0; k < 300; k++) begin
         set_rand();
         xi = int'($urandom_range(0, 12));
         yi = int'($urandom_range(0, 12));
         dv = 1'($urandom_range(0, 1));
         hs = 1'($urandom_range(0, 1));
         vs = ($urandom_range(0, 7) == 0);
         we = ($urandom_range(0, 2) == 0);
         addr = int'($urandom_range(0, 31));
         data = int'($urandom_range(0, 255)) - 128;
         apply("random");
      end
      we = 1'b0; vs = 1'b0;

      // reset during a pixel ramp; kernel reverts to identity
      load_kernel(1, 1);
      xi = 10; yi = 10; dv = 1'b1;
      for (int k = 0; k < 6; k++) begin
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               p[r][c] = (k * 9 + r * 5 + c) & 255;
         apply("ramp_pre");
      end
      pulse_reset("reset_mid");
      for (int k = 0; k < 8; k++) begin
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               p[r][c] = (k * 11 + r * 5 + c + 40) & 255;
         apply("ramp_post");
      end
      dv = 1'b0;
      for (int k = 0; k < LAT; k++) begin set_rand(); apply("drain"); end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
